// File: rtl/alu_pkg.sv
// Shared ALU definitions: select codes, RV32I opcodes and funct7 values.
package alu_pkg;

  localparam logic [3:0] ALU_FWD  = 4'd0;
  localparam logic [3:0] ALU_ADD  = 4'd1;
  localparam logic [3:0] ALU_AND  = 4'd2;
  localparam logic [3:0] ALU_OR   = 4'd3;
  localparam logic [3:0] ALU_SUB  = 4'd4;
  localparam logic [3:0] ALU_XOR  = 4'd5;
  localparam logic [3:0] ALU_SLL  = 4'd6;
  localparam logic [3:0] ALU_SRL  = 4'd7;
  localparam logic [3:0] ALU_SRA  = 4'd8;
  localparam logic [3:0] ALU_SLT  = 4'd9;
  localparam logic [3:0] ALU_SLTU = 4'd10;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  localparam logic [6:0] F7_BASE   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  // Operation for the funct3 slot when funct7 carries no alternate meaning.
  function automatic logic [3:0] base_sel(input logic [2:0] f3);
    case (f3)
      3'b000:  base_sel = ALU_ADD;
      3'b001:  base_sel = ALU_SLL;
      3'b010:  base_sel = ALU_SLT;
      3'b011:  base_sel = ALU_SLTU;
      3'b100:  base_sel = ALU_XOR;
      3'b101:  base_sel = ALU_SRL;
      3'b110:  base_sel = ALU_OR;
      default: base_sel = ALU_AND;
    endcase
  endfunction

endpackage

// File: rtl/alu_decode.sv
// Combinational RV32I integer decode into ALU operands and select.
module alu_decode
  import alu_pkg::*;
(
  input  logic [31:0] i_instr,
  input  logic [31:0] i_pc,
  input  logic [31:0] i_rs1,
  input  logic [31:0] i_rs2,
  output logic [31:0] o_data1,
  output logic [31:0] o_data2,
  output logic [3:0]  o_select,
  output logic [4:0]  o_rd,
  output logic        o_rd_wen,
  output logic        o_illegal
);

  logic [6:0]  w_opcode;
  logic [2:0]  w_f3;
  logic [6:0]  w_f7;
  logic [4:0]  w_shamt;
  logic [31:0] w_imm_i;
  logic [31:0] w_imm_u;
  logic [3:0]  w_sel;
  logic        w_legal;

  assign w_opcode = i_instr[6:0];
  assign w_f3     = i_instr[14:12];
  assign w_f7     = i_instr[31:25];
  assign w_shamt  = i_instr[24:20];
  assign w_imm_i  = {{20{i_instr[31]}}, i_instr[31:20]};
  assign w_imm_u  = {i_instr[31:12], 12'b0};

  // Opcode decode; operands default to the register ports.
  always_comb begin
    o_data1 = i_rs1;
    o_data2 = i_rs2;
    w_sel   = ALU_FWD;
    w_legal = 1'b1;
    case (w_opcode)
      OPC_OP: begin
        if (w_f7 == F7_BASE)                        w_sel = base_sel(w_f3);
        else if (w_f7 == F7_ALT && w_f3 == 3'b000)  w_sel = ALU_SUB;
        else if (w_f7 == F7_ALT && w_f3 == 3'b101)  w_sel = ALU_SRA;
        else if (w_f7 == F7_MULDIV)                 w_legal = 1'b0; // M extension lives elsewhere
        else                                        w_legal = 1'b0;
      end
      OPC_OP_IMM: begin
        if (w_f3 == 3'b001 || w_f3 == 3'b101) begin
          o_data2 = {27'b0, w_shamt};
          if (w_f3 == 3'b001 && w_f7 == F7_BASE)     w_sel = ALU_SLL;
          else if (w_f3 == 3'b101 && w_f7 == F7_BASE) w_sel = ALU_SRL;
          else if (w_f3 == 3'b101 && w_f7 == F7_ALT)  w_sel = ALU_SRA;
          else                                       w_legal = 1'b0;
        end else begin
          o_data2 = w_imm_i;
          w_sel   = base_sel(w_f3);
        end
      end
      OPC_LUI: begin
        // rs1 field is part of the immediate here, so operand A is zeroed.
        o_data1 = '0;
        o_data2 = w_imm_u;
      end
      OPC_AUIPC: begin
        o_data1 = i_pc;
        o_data2 = w_imm_u;
        w_sel   = ALU_ADD;
      end
      OPC_JAL, OPC_JALR: begin
        o_data1 = i_pc;
        o_data2 = 32'd4;
        w_sel   = ALU_ADD;
      end
      default: w_legal = 1'b0;
    endcase
  end

  assign o_select  = w_legal ? w_sel : ALU_FWD;
  assign o_rd      = i_instr[11:7];
  assign o_rd_wen  = w_legal && (o_rd != 5'd0);
  assign o_illegal = !w_legal;

endmodule

// File: rtl/alu_issue_stage.sv
// ID/EX issue register: decodes one instruction and holds it for EX
// behind a valid/ready handshake, with flush for branch redirects.
module alu_issue_stage #(
  parameter int XLEN  = 32,
  parameter int SEL_W = 4
) (
  input  logic             CLK,
  input  logic             RESETN,
  input  logic             IN_VALID,
  output logic             IN_READY,
  input  logic [31:0]      INSTR,
  input  logic [XLEN-1:0]  PC,
  input  logic [XLEN-1:0]  RS1_DATA,
  input  logic [XLEN-1:0]  RS2_DATA,
  input  logic             FLUSH,
  output logic             OUT_VALID,
  input  logic             OUT_READY,
  output logic [XLEN-1:0]  DATA1,
  output logic [XLEN-1:0]  DATA2,
  output logic [SEL_W-1:0] SELECT,
  output logic [4:0]       RD_ADDR,
  output logic             RD_WEN,
  output logic             ILLEGAL
);
  import alu_pkg::*;

  logic [XLEN-1:0]  w_data1;
  logic [XLEN-1:0]  w_data2;
  logic [SEL_W-1:0] w_sel;
  logic [4:0]       w_rd;
  logic             w_rd_wen;
  logic             w_illegal;
  logic             w_in_ready;
  logic             w_load;

  logic             r_valid;
  logic [XLEN-1:0]  r_data1;
  logic [XLEN-1:0]  r_data2;
  logic [SEL_W-1:0] r_select;
  logic [4:0]       r_rd;
  logic             r_rd_wen;
  logic             r_illegal;

  alu_decode u_decode (
    .i_instr   (INSTR),
    .i_pc      (PC),
    .i_rs1     (RS1_DATA),
    .i_rs2     (RS2_DATA),
    .o_data1   (w_data1),
    .o_data2   (w_data2),
    .o_select  (w_sel),
    .o_rd      (w_rd),
    .o_rd_wen  (w_rd_wen),
    .o_illegal (w_illegal)
  );

  assign w_in_ready = !r_valid || OUT_READY;
  assign w_load     = IN_VALID && w_in_ready && !FLUSH;

  // Issue register: flush beats load, load beats drain; data only moves on load.
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      r_valid   <= 1'b0;
      r_data1   <= '0;
      r_data2   <= '0;
      r_select  <= ALU_FWD;
      r_rd      <= '0;
      r_rd_wen  <= 1'b0;
      r_illegal <= 1'b0;
    end else if (FLUSH) begin
      r_valid  <= 1'b0;
      r_rd_wen <= 1'b0;
    end else if (w_load) begin
      r_valid   <= 1'b1;
      r_data1   <= w_data1;
      r_data2   <= w_data2;
      r_select  <= w_sel;
      r_rd      <= w_rd;
      r_rd_wen  <= w_rd_wen;
      r_illegal <= w_illegal;
    end else if (OUT_READY) begin
      r_valid <= 1'b0;
    end
  end

  assign IN_READY  = w_in_ready;
  assign OUT_VALID = r_valid;
  assign DATA1     = r_data1;
  assign DATA2     = r_data2;
  assign SELECT    = r_select;
  assign RD_ADDR   = r_rd;
  assign RD_WEN    = r_rd_wen;
  assign ILLEGAL   = r_illegal;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Scoreboard bench for alu_issue_stage: directed scenarios plus random traffic.
module tb_alu_issue_stage;

  logic        CLK = 1'b0;
  logic        RESETN = 1'b0;
  logic        IN_VALID = 1'b0;
  logic        FLUSH = 1'b0;
  logic        OUT_READY = 1'b0;
  logic [31:0] INSTR = '0;
  logic [31:0] PC = '0;
  logic [31:0] RS1_DATA = '0;
  logic [31:0] RS2_DATA = '0;
  logic        IN_READY, OUT_VALID, RD_WEN, ILLEGAL;
  logic [31:0] DATA1, DATA2;
  logic [3:0]  SELECT;
  logic [4:0]  RD_ADDR;

  alu_issue_stage dut (
    .CLK(CLK), .RESETN(RESETN), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
    .INSTR(INSTR), .PC(PC), .RS1_DATA(RS1_DATA), .RS2_DATA(RS2_DATA),
    .FLUSH(FLUSH), .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY),
    .DATA1(DATA1), .DATA2(DATA2), .SELECT(SELECT), .RD_ADDR(RD_ADDR),
    .RD_WEN(RD_WEN), .ILLEGAL(ILLEGAL)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [31:0] d1, d2;
    logic [3:0]  sel;
    logic [4:0]  rd;
    logic        wen, ill, chk_data, chk_sel;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;
  logic m_valid = 1'b0;      // expected OUT_VALID after the next edge
  logic m_valid_cur = 1'b0;  // expected OUT_VALID in the current cycle
  logic m_ready_cur = 1'b1;  // expected IN_READY in the current cycle

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, req);
    end
  endtask

  // Reference: RV32I semantics written out per mnemonic.
  function automatic exp_t model(input logic [31:0] ins, input logic [31:0] pc,
                                 input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    logic [3:0]  tbl [8];
    logic [6:0]  op, f7;
    logic [2:0]  f3;
    logic [31:0] imm_i, imm_u;
    tbl[0] = 4'd1;  tbl[1] = 4'd6;  tbl[2] = 4'd9; tbl[3] = 4'd10;
    tbl[4] = 4'd5;  tbl[5] = 4'd7;  tbl[6] = 4'd3; tbl[7] = 4'd2;
    op = ins[6:0]; f3 = ins[14:12]; f7 = ins[31:25];
    imm_i = {{20{ins[31]}}, ins[31:20]};
    imm_u = {ins[31:12], 12'h000};
    e.d1 = a; e.d2 = b; e.sel = 4'd0; e.ill = 1'b0;
    e.chk_data = 1'b1; e.chk_sel = 1'b1;
    if (op == 7'b0110011) begin
      if (f7 == 7'h00) e.sel = tbl[f3];
      else if (f7 == 7'h20 && f3 == 3'd0) e.sel = 4'd4;
      else if (f7 == 7'h20 && f3 == 3'd5) e.sel = 4'd8;
      else begin e.ill = 1'b1; e.chk_data = 1'b0; e.chk_sel = 1'b0; end
    end else if (op == 7'b0010011) begin
      if (f3 == 3'd1 || f3 == 3'd5) begin
        e.d2 = 32'(ins[24:20]);
        if (f7 == 7'h00) e.sel = (f3 == 3'd1) ? 4'd6 : 4'd7;
        else if (f7 == 7'h20 && f3 == 3'd5) e.sel = 4'd8;
        else begin e.ill = 1'b1; e.chk_data = 1'b0; e.chk_sel = 1'b0; end
      end else begin
        e.d2 = imm_i; e.sel = tbl[f3];
      end
    end else if (op == 7'b0110111) begin
      e.d1 = 32'd0; e.d2 = imm_u; e.sel = 4'd0;
    end else if (op == 7'b0010111) begin
      e.d1 = pc; e.d2 = imm_u; e.sel = 4'd1;
    end else if (op == 7'b1101111 || op == 7'b1100111) begin
      e.d1 = pc; e.d2 = 32'd4; e.sel = 4'd1;
    end else begin
      e.ill = 1'b1; e.sel = 4'd0; e.chk_data = 1'b0;
    end
    e.rd  = ins[11:7];
    e.wen = !e.ill && (ins[11:7] != 5'd0);
    return e;
  endfunction

  function automatic logic [6:0] pick_f7();
    case ($urandom_range(0, 3))
      0:       return 7'h00;
      1:       return 7'h20;
      2:       return 7'h01;
      default: return 7'($urandom);
    endcase
  endfunction

  function automatic logic [31:0] gen_instr();
    logic [31:0] w;
    w = $urandom;
    case ($urandom_range(0, 9))
      0, 1, 2: begin w[6:0] = 7'b0110011; w[31:25] = pick_f7(); end
      3, 4: begin
        w[6:0] = 7'b0010011;
        if (w[13:12] == 2'b01) w[31:25] = pick_f7();
      end
      5: w[6:0] = 7'b0110111;
      6: w[6:0] = 7'b0010111;
      7: w[6:0] = 7'b1101111;
      8: w[6:0] = 7'b1100111;
      default: ;
    endcase
    return w;
  endfunction

  // One clock of stimulus; called at posedge+1, returns at the next posedge+1.
  task automatic cycle(input logic iv, input logic [31:0] ins, input logic [31:0] pc,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic ordy, input logic fl);
    logic rdy, ld;
    IN_VALID = iv; INSTR = ins; PC = pc; RS1_DATA = a; RS2_DATA = b;
    OUT_READY = ordy; FLUSH = fl;
    rdy = !m_valid || ordy;
    ld  = iv && rdy && !fl;
    m_valid_cur = m_valid;
    m_ready_cur = rdy;
    if (fl) begin
      sb.delete();
      m_valid = 1'b0;
    end else if (ld) begin
      sb.push_back(model(ins, pc, a, b));
      m_valid = 1'b1;
    end else if (ordy) begin
      m_valid = 1'b0;
    end
    @(posedge CLK);
    #1;
  endtask

  // Monitor: compares the presented entry every valid cycle, pops on handshake.
  always @(negedge CLK) begin
    exp_t e;
    if (RESETN) begin
      chk("mon_out_valid", 32'(OUT_VALID), 32'(m_valid_cur));
      chk("mon_in_ready", 32'(IN_READY), 32'(m_ready_cur));
      if (OUT_VALID && OUT_READY) chk("mon_entry_expected", 32'(sb.size() != 0), 32'd1);
      if (OUT_VALID && sb.size() != 0) begin
        e = sb[0];
        chk("mon_rd_addr", 32'(RD_ADDR), 32'(e.rd));
        chk("mon_rd_wen", 32'(RD_WEN), 32'(e.wen));
        chk("mon_illegal", 32'(ILLEGAL), 32'(e.ill));
        if (e.chk_sel) chk("mon_select", 32'(SELECT), 32'(e.sel));
        if (e.chk_data) begin
          chk("mon_data1", DATA1, e.d1);
          chk("mon_data2", DATA2, e.d2);
        end
        if (OUT_READY) void'(sb.pop_front());
      end
    end
  end

  localparam logic [31:0] I_ADD = 32'h002083B3; // add x7,x1,x2
  localparam logic [31:0] I_XOR = 32'h0041C433; // xor x8,x3,x4

  initial begin
    #7;
    chk("rst_out_valid", 32'(OUT_VALID), 0);
    chk("rst_data1", DATA1, 0);
    chk("rst_data2", DATA2, 0);
    chk("rst_select", 32'(SELECT), 0);
    chk("rst_rd_addr", 32'(RD_ADDR), 0);
    chk("rst_rd_wen", 32'(RD_WEN), 0);
    chk("rst_illegal", 32'(ILLEGAL), 0);
    chk("rst_in_ready", 32'(IN_READY), 1);
    @(posedge CLK);
    #1 RESETN = 1'b1;

    // ADDI x5,x1,-1
    cycle(1, 32'hFFF08293, 32'h100, 32'h10, 32'h0, 1, 0);
    chk("addi_valid", 32'(OUT_VALID), 1);
    chk("addi_data1", DATA1, 32'h10);
    chk("addi_data2", DATA2, 32'hFFFFFFFF);
    chk("addi_select", 32'(SELECT), 1);
    chk("addi_rd", 32'(RD_ADDR), 5);
    chk("addi_wen", 32'(RD_WEN), 1);

    // LUI then SUB back-to-back
    cycle(1, 32'h123451B7, 32'h104, $urandom, $urandom, 1, 0);
    chk("lui_data2", DATA2, 32'h12345000);
    chk("lui_select", 32'(SELECT), 0);
    cycle(1, 32'h40418133, 32'h108, $urandom, $urandom, 1, 0);
    chk("sub_valid", 32'(OUT_VALID), 1);
    chk("sub_select", 32'(SELECT), 4);
    chk("sub_rd", 32'(RD_ADDR), 2);
    cycle(0, 0, 0, 0, 0, 1, 0);
    chk("drain_valid", 32'(OUT_VALID), 0);

    // Stall for three cycles with the next instruction waiting
    cycle(1, I_ADD, 32'h200, 32'h11, 32'h22, 0, 0);
    for (int i = 0; i < 3; i++) begin
      cycle(1, I_XOR, 32'h204, 32'h33, 32'h44, 0, 0);
      chk("hold_in_ready", 32'(IN_READY), 0);
      chk("hold_select", 32'(SELECT), 1);
      chk("hold_data1", DATA1, 32'h11);
    end
    cycle(1, I_XOR, 32'h204, 32'h33, 32'h44, 1, 0);
    chk("after_hold_select", 32'(SELECT), 5);
    chk("after_hold_rd", 32'(RD_ADDR), 8);
    cycle(0, 0, 0, 0, 0, 1, 0);

    // Flush kills both the held and the incoming entry
    cycle(1, I_ADD, 32'h300, 32'h1, 32'h2, 0, 0);
    cycle(1, I_XOR, 32'h304, 32'h3, 32'h4, 0, 1);
    chk("flush_valid", 32'(OUT_VALID), 0);
    chk("flush_rd_wen", 32'(RD_WEN), 0);
    cycle(0, 0, 0, 0, 0, 1, 0);
    cycle(0, 0, 0, 0, 0, 1, 0);
    chk("flush_stays_empty", 32'(OUT_VALID), 0);

    // MUL is illegal here; ADDI x0 writes nothing
    cycle(1, 32'h023100B3, 32'h400, $urandom, $urandom, 1, 0);
    chk("mul_valid", 32'(OUT_VALID), 1);
    chk("mul_illegal", 32'(ILLEGAL), 1);
    chk("mul_rd_wen", 32'(RD_WEN), 0);
    cycle(1, 32'h00000013, 32'h404, 0, 0, 1, 0);
    chk("nop_rd_wen", 32'(RD_WEN), 0);
    chk("nop_illegal", 32'(ILLEGAL), 0);
    cycle(0, 0, 0, 0, 0, 1, 0);

    // Asynchronous reset in the middle of a hold
    cycle(1, I_ADD, 32'h500, 32'h55, 32'h66, 0, 0);
    cycle(1, I_XOR, 32'h504, 32'h77, 32'h88, 0, 0);
    #3 RESETN = 1'b0;
    #1;
    chk("arst_out_valid", 32'(OUT_VALID), 0);
    chk("arst_data1", DATA1, 0);
    chk("arst_data2", DATA2, 0);
    chk("arst_select", 32'(SELECT), 0);
    chk("arst_rd_addr", 32'(RD_ADDR), 0);
    chk("arst_rd_wen", 32'(RD_WEN), 0);
    chk("arst_illegal", 32'(ILLEGAL), 0);
    sb.delete();
    m_valid = 1'b0; m_valid_cur = 1'b0; m_ready_cur = 1'b1;
    IN_VALID = 1'b0;
    #2 RESETN = 1'b1;
    chk("arst_in_ready", 32'(IN_READY), 1);
    @(posedge CLK);
    #1;

    // Random traffic
    for (int n = 0; n < 400; n++) begin
      logic iv, ordy, fl;
      iv   = ($urandom_range(0, 3) != 0);
      ordy = ($urandom_range(0, 3) != 0);
      fl   = ($urandom_range(0, 15) == 0);
      if (fl) ordy = 1'b0;
      cycle(iv, gen_instr(), $urandom, $urandom, $urandom, ordy, fl);
    end
    repeat (3) cycle(0, 0, 0, 0, 0, 1, 0);
    chk("sb_drained", 32'(sb.size()), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
